// File: rtl/led_strip_tx.sv
// led_strip_tx: WS2812-class NRZ transmitter taking 24-bit RGB pixels over valid/ready.
// Define LED_TX_UNDERRUN_EN to abort a frame once a mid-frame gap outlasts the latch interval.
module led_strip_tx #(
    parameter int NUM_PIXELS = 8,
    parameter int BIT_CYC    = 63,
    parameter int T0H_CYC    = 20,
    parameter int T1H_CYC    = 40,
    parameter int RESET_CYC  = 15000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] pixel_in,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        dout,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);
    localparam int CW = $clog2(BIT_CYC) + 1;
    localparam int GW = $clog2(RESET_CYC) + 1;
    localparam int PW = $clog2(NUM_PIXELS) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] T0H = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H = CW'(T1H_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'(RESET_CYC - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(RESET_CYC);
    localparam logic [PW-1:0] PIX_NUM = PW'(NUM_PIXELS);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, LATCH} state_t;
    state_t state, state_n;
    logic [23:0] sh, sh_n;
    logic [4:0] bit_cnt, bit_n;
    logic [CW-1:0] cyc_cnt, cyc_n;
    logic [PW-1:0] pix_cnt, pix_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic dout_n, done_n, urun_n, accept, bit_end, pix_end, last_pix;
    assign bit_end = cyc_cnt == CYC_LAST;
    assign pix_end = state == SEND && bit_end && bit_cnt == 5'd23;
    assign last_pix = pix_cnt + 1'b1 == PIX_NUM;
    assign pixel_ready = state == IDLE || state == WAIT || (pix_end && !last_pix);
    assign accept = pixel_valid && pixel_ready;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        sh_n = sh;
        bit_n = bit_cnt;
        cyc_n = cyc_cnt;
        pix_n = pix_cnt;
        gap_n = gap_cnt;
        done_n = 1'b0;
        urun_n = 1'b0;
        if (accept) begin
            state_n = SEND;
            sh_n = {pixel_in[15:8], pixel_in[23:16], pixel_in[7:0]};
            bit_n = '0;
            cyc_n = '0;
            gap_n = '0;
            pix_n = pix_end ? pix_cnt + 1'b1 : pix_cnt;
        end else begin
            case (state)
                SEND: begin
                    cyc_n = bit_end ? '0 : cyc_cnt + 1'b1;
                    if (bit_end) begin
                        sh_n = {sh[22:0], 1'b0};
                        bit_n = bit_cnt + 5'd1;
                    end
                    if (pix_end) begin
                        bit_n = '0;
                        gap_n = '0;
                        pix_n = pix_cnt + 1'b1;
                        state_n = last_pix ? LATCH : WAIT;
                    end
                end
                WAIT: begin
`ifdef LED_TX_UNDERRUN_EN
                    // strip has already latched the partial frame, so restart cleanly
                    if (gap_cnt == GAP_LAST) begin
                        urun_n = 1'b1;
                        pix_n = '0;
                        gap_n = '0;
                        state_n = IDLE;
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
`else
                    gap_n = gap_cnt == GAP_MAX ? gap_cnt : gap_cnt + 1'b1;
`endif
                end
                LATCH: begin
                    gap_n = gap_cnt == GAP_LAST ? '0 : gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        done_n = 1'b1;
                        pix_n = '0;
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
        // dout is registered from next-state values so it lines up with cyc_cnt
        dout_n = state_n == SEND && cyc_n < (sh_n[23] ? T1H : T0H);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            pix_cnt <= '0;
            gap_cnt <= '0;
            dout <= 1'b0;
            frame_done <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state <= state_n;
            sh <= sh_n;
            bit_cnt <= bit_n;
            cyc_cnt <= cyc_n;
            pix_cnt <= pix_n;
            gap_cnt <= gap_n;
            dout <= dout_n;
            frame_done <= done_n;
            underrun <= urun_n;
        end
    end
endmodule
